// File: rtl/alarm_controller.sv
// alarm_controller: compares the running BCD time against a stored alarm time and runs the
// ring / snooze / stop sequence that drives the buzzer. All timing is in whole seconds,
// counted on the 1 Hz SEC_TICK enable pulse.
//
// Ports:
//   Clk       system clock, all logic on posedge
//   Clr       synchronous reset, active-low
//   SEC_TICK  1-cycle pulse, once per second
//   HR_T/HR_U/MIN_T/MIN_U  current time digits (BCD)
//   ALM_IN    alarm time {HR_T,HR_U,MIN_T,MIN_U}, loaded when LD_ALM is high
//   LD_ALM    load ALM_IN into the alarm register
//   ALM_EN    alarm armed (level)
//   SNOOZE    snooze request, acted on only while ringing
//   STOP      stop request, acted on while ringing or snoozing
//   BUZZ      buzzer drive (registered)
//   RINGING   alarm is ringing
//   SNOOZING  alarm is snoozing
//   ALM_TIME  stored alarm time
//
// Build option: define ALARM_BEEP_EN for a 1 s on / 1 s off beep while ringing;
// left undefined, BUZZ is a steady tone equal to RINGING.
module alarm_controller #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 540
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        SEC_TICK,
  input  logic [1:0]  HR_T,
  input  logic [3:0]  HR_U,
  input  logic [2:0]  MIN_T,
  input  logic [3:0]  MIN_U,
  input  logic [12:0] ALM_IN,
  input  logic        LD_ALM,
  input  logic        ALM_EN,
  input  logic        SNOOZE,
  input  logic        STOP,
  output logic        BUZZ,
  output logic        RINGING,
  output logic        SNOOZING,
  output logic [12:0] ALM_TIME
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRing = 2'd1,
    StSnz  = 2'd2
  } state_e;

  localparam logic [9:0] RingLast = 10'(RING_SECS - 1);
  localparam logic [9:0] SnzInit  = 10'(SNOOZE_SECS);

  state_e      state_q, state_d;
  logic [9:0]  ring_cnt_q, ring_cnt_d;
  logic [9:0]  snz_cnt_q, snz_cnt_d;
  logic [12:0] alm_time_q, alm_time_d;
  logic        match_q, match_d;
  logic        buzz_q, buzz_d;

  logic [12:0] cur_time;
  logic        match;
  logic        trigger;

  assign cur_time = {HR_T, HR_U, MIN_T, MIN_U};
  assign match    = (alm_time_q == cur_time);
  // Ring only on entry into the matching minute, not for the whole minute.
  assign trigger  = match & ~match_q;

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    alm_time_d = alm_time_q;
    match_d    = match;

    if (LD_ALM) begin
      alm_time_d = ALM_IN;
      state_d    = StIdle;
      // Compare against the new alarm so loading the current time does not ring at once.
      match_d    = (ALM_IN == cur_time);
    end else if (!ALM_EN) begin
      state_d = StIdle;
    end else if (STOP && (state_q != StIdle)) begin
      state_d = StIdle;
    end else if (SNOOZE && (state_q == StRing)) begin
      state_d   = StSnz;
      snz_cnt_d = SnzInit;
    end else begin
      case (state_q)
        StIdle: begin
          if (trigger) begin
            state_d    = StRing;
            ring_cnt_d = '0;
          end
        end
        StRing: begin
          if (SEC_TICK) begin
            if (ring_cnt_q == RingLast) begin
              state_d = StIdle;
            end else begin
              ring_cnt_d = ring_cnt_q + 10'd1;
            end
          end
        end
        StSnz: begin
          if (SEC_TICK) begin
            if (snz_cnt_q == 10'd1) begin
              state_d    = StRing;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q - 10'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    buzz_d = 1'b0;
`ifdef ALARM_BEEP_EN
    if (state_d == StRing) begin
      if (state_q != StRing) begin
        buzz_d = 1'b1;
      end else if (SEC_TICK) begin
        buzz_d = ~buzz_q;
      end else begin
        buzz_d = buzz_q;
      end
    end
`else
    buzz_d = (state_d == StRing);
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q    <= StIdle;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      alm_time_q <= '0;
      match_q    <= 1'b1;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      alm_time_q <= alm_time_d;
      match_q    <= match_d;
      buzz_q     <= buzz_d;
    end
  end

  assign BUZZ     = buzz_q;
  assign RINGING  = (state_q == StRing);
  assign SNOOZING = (state_q == StSnz);
  assign ALM_TIME = alm_time_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural model of the alarm clock.
module tb_alarm_controller;

  localparam int unsigned RingSecs   = 4;
  localparam int unsigned SnoozeSecs = 3;

  logic        Clk;
  logic        Clr;
  logic        SEC_TICK;
  logic [1:0]  HR_T;
  logic [3:0]  HR_U;
  logic [2:0]  MIN_T;
  logic [3:0]  MIN_U;
  logic [12:0] ALM_IN;
  logic        LD_ALM;
  logic        ALM_EN;
  logic        SNOOZE;
  logic        STOP;
  logic        BUZZ;
  logic        RINGING;
  logic        SNOOZING;
  logic [12:0] ALM_TIME;

  alarm_controller #(
    .RING_SECS  (RingSecs),
    .SNOOZE_SECS(SnoozeSecs)
  ) u_dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .SEC_TICK(SEC_TICK),
    .HR_T    (HR_T),
    .HR_U    (HR_U),
    .MIN_T   (MIN_T),
    .MIN_U   (MIN_U),
    .ALM_IN  (ALM_IN),
    .LD_ALM  (LD_ALM),
    .ALM_EN  (ALM_EN),
    .SNOOZE  (SNOOZE),
    .STOP    (STOP),
    .BUZZ    (BUZZ),
    .RINGING (RINGING),
    .SNOOZING(SNOOZING),
    .ALM_TIME(ALM_TIME)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: an alarm clock described in seconds elapsed / remaining.
  logic [12:0] m_alarm;
  bit          m_prev_match;
  bit          m_ring;
  bit          m_snz;
  int          m_ring_ticks;   // seconds since ringing (re)started
  int          m_snz_left;     // seconds of snooze remaining

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] bcd_time(input int unsigned h, input int unsigned m);
    logic [12:0] t;
    t[12:11] = 2'(h / 10);
    t[10:7]  = 4'(h % 10);
    t[6:4]   = 3'(m / 10);
    t[3:0]   = 4'(m % 10);
    return t;
  endfunction

  task automatic set_time(input int unsigned h, input int unsigned m);
    logic [12:0] t;
    t = bcd_time(h, m);
    {HR_T, HR_U, MIN_T, MIN_U} = t;
  endtask

  function automatic bit model_buzz();
`ifdef ALARM_BEEP_EN
    return m_ring && ((m_ring_ticks % 2) == 0);
`else
    return m_ring;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [12:0] cur;
    bit          now_match;
    bit          rising;
    bit          next_prev;
    cur = {HR_T, HR_U, MIN_T, MIN_U};
    if (!Clr) begin
      m_alarm      = '0;
      m_prev_match = 1'b1;
      m_ring       = 1'b0;
      m_snz        = 1'b0;
      m_ring_ticks = 0;
      m_snz_left   = 0;
      return;
    end
    now_match = (m_alarm == cur);
    rising    = now_match && !m_prev_match;
    next_prev = LD_ALM ? (ALM_IN == cur) : now_match;
    if (LD_ALM) begin
      m_alarm = ALM_IN;
      m_ring  = 1'b0;
      m_snz   = 1'b0;
    end else if (!ALM_EN) begin
      m_ring = 1'b0;
      m_snz  = 1'b0;
    end else if (STOP && (m_ring || m_snz)) begin
      m_ring = 1'b0;
      m_snz  = 1'b0;
    end else if (SNOOZE && m_ring) begin
      m_ring     = 1'b0;
      m_snz      = 1'b1;
      m_snz_left = SnoozeSecs;
    end else if (m_ring) begin
      if (SEC_TICK) begin
        m_ring_ticks++;
        if (m_ring_ticks == RingSecs) m_ring = 1'b0;
      end
    end else if (m_snz) begin
      if (SEC_TICK) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_snz        = 1'b0;
          m_ring       = 1'b1;
          m_ring_ticks = 0;
        end
      end
    end else if (rising) begin
      m_ring       = 1'b1;
      m_ring_ticks = 0;
    end
    m_prev_match = next_prev;
  endtask

  // One clock: update model, let the edge pass, compare away from the edge.
  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    check_eq("ringing", 32'(RINGING), 32'(m_ring));
    check_eq("snoozing", 32'(SNOOZING), 32'(m_snz));
    check_eq("buzz", 32'(BUZZ), 32'(model_buzz()));
    check_eq("alm_time", 32'(ALM_TIME), 32'(m_alarm));
  endtask

  task automatic tick();
    SEC_TICK = 1'b1;
    cycle();
    SEC_TICK = 1'b0;
    cycle();
  endtask

  task automatic retrigger();
    set_time(7, 29);
    cycle();
    set_time(7, 30);
    cycle();
  endtask

  initial begin
    Clr      = 1'b0;
    SEC_TICK = 1'b0;
    ALM_IN   = '0;
    LD_ALM   = 1'b0;
    ALM_EN   = 1'b1;
    SNOOZE   = 1'b0;
    STOP     = 1'b0;
    set_time(0, 0);
    m_alarm      = '0;
    m_prev_match = 1'b1;
    m_ring       = 1'b0;
    m_snz        = 1'b0;
    m_ring_ticks = 0;
    m_snz_left   = 0;

    cycle();
    cycle();
    check_eq("rst_ringing", 32'(RINGING), 32'd0);
    check_eq("rst_buzz", 32'(BUZZ), 32'd0);
    check_eq("rst_alm_time", 32'(ALM_TIME), 32'd0);

    // Time == alarm == 00:00 straight out of reset must stay silent.
    Clr = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("rst_match_quiet", 32'(RINGING), 32'd0);
    check_eq("rst_match_buzz", 32'(BUZZ), 32'd0);

    // Load 07:30, step 07:29 -> 07:30.
    set_time(7, 29);
    ALM_IN = bcd_time(7, 30);
    LD_ALM = 1'b1;
    cycle();
    LD_ALM = 1'b0;
    cycle();
    check_eq("load_alm", 32'(ALM_TIME), 32'(13'h3B0));
    set_time(7, 30);
    cycle();
    check_eq("ring_latency", 32'(RINGING), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("ring_3_ticks", 32'(RINGING), 32'd1);
    tick();
    check_eq("ring_auto_off", 32'(RINGING), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("no_rering", 32'(RINGING), 32'd0);

    // Snooze then re-ring, then stop.
    retrigger();
    check_eq("ring_again", 32'(RINGING), 32'd1);
    SNOOZE = 1'b1;
    cycle();
    SNOOZE = 1'b0;
    check_eq("snz_entry", 32'(SNOOZING), 32'd1);
    check_eq("snz_buzz", 32'(BUZZ), 32'd0);
    for (int i = 0; i < 2; i++) tick();
    check_eq("snz_2_ticks", 32'(SNOOZING), 32'd1);
    tick();
    check_eq("snz_rering", 32'(RINGING), 32'd1);
    STOP = 1'b1;
    cycle();
    STOP = 1'b0;
    check_eq("stop_idle", 32'(RINGING), 32'd0);

    // STOP beats SNOOZE in the same cycle.
    retrigger();
    STOP   = 1'b1;
    SNOOZE = 1'b1;
    cycle();
    STOP   = 1'b0;
    SNOOZE = 1'b0;
    check_eq("stop_snz_ring", 32'(RINGING), 32'd0);
    check_eq("stop_snz_snz", 32'(SNOOZING), 32'd0);

    // Disarm during snooze.
    retrigger();
    SNOOZE = 1'b1;
    cycle();
    SNOOZE = 1'b0;
    ALM_EN = 1'b0;
    cycle();
    ALM_EN = 1'b1;
    check_eq("disarm_snz", 32'(SNOOZING), 32'd0);

    // Buzz pattern across ticks.
    retrigger();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_b;
`ifdef ALARM_BEEP_EN
      exp_b = ((i % 2) == 0) ? 32'd1 : 32'd0;
`else
      exp_b = 32'd1;
`endif
      check_eq("buzz_pattern", 32'(BUZZ), exp_b);
      SEC_TICK = 1'b1;
      cycle();
      SEC_TICK = 1'b0;
    end
    check_eq("buzz_after_ring", 32'(BUZZ), 32'd0);

    // Reset asserted mid-ring: nothing changes until the edge.
    retrigger();
    Clr = 1'b0;
    #2;
    check_eq("clr_no_edge", 32'(RINGING), 32'd1);
    cycle();
    check_eq("clr_ringing", 32'(RINGING), 32'd0);
    check_eq("clr_buzz", 32'(BUZZ), 32'd0);
    check_eq("clr_alm_time", 32'(ALM_TIME), 32'd0);
    Clr = 1'b1;
    cycle();

    // Loading the current time stays quiet until the next matching minute.
    ALM_IN = bcd_time(7, 30);
    LD_ALM = 1'b1;
    cycle();
    LD_ALM = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("ld_equal_quiet", 32'(RINGING), 32'd0);
    set_time(7, 31);
    cycle();
    set_time(7, 30);
    cycle();
    check_eq("ld_equal_next", 32'(RINGING), 32'd1);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      SEC_TICK = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) set_time(7, $urandom_range(28, 31));
      LD_ALM = ($urandom_range(0, 99) == 0);
      ALM_IN = bcd_time(7, $urandom_range(28, 31));
      ALM_EN = ($urandom_range(0, 59) != 0);
      SNOOZE = ($urandom_range(0, 19) == 0);
      STOP   = ($urandom_range(0, 39) == 0);
      Clr    = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
